// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cpu_types_pkg
//  Purpose : Shared types for the dual-core coherence bus. Holds the
//            bus_state_t controller states, the word_t data word and the
//            per-core word array, plus a small helper that names the
//            snooped core.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int CPUS_DEF   = 2;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef word_t [CPUS_DEF-1:0]  word_per_cpu_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SNOOP  = 3'd1,
        C2C    = 3'd2,
        RAM_RD = 3'd3,
        DWRITE = 3'd4,
        IFETCH = 3'd5
    } bus_state_t;

    // With exactly two cores, the snooped core is always the other one.
    function automatic logic other_core(input logic core);
        return ~core;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter2
//  Purpose : Two-requester round-robin arbiter. The pointer names the
//            favoured requester and toggles only when the owner of the
//            current grant reports completion through 'advance'.
//  Ports   : clk, rst_n   - clock, asynchronous active-low reset
//            req[1:0]     - request per requester
//            advance      - current grant completed; rotate priority
//            grant        - index of the winning requester
//            any          - at least one requester is active
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant,
    output logic       any
);

    logic r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~r_ptr;
        end
    end

    // The favoured requester wins whenever it asks, or when nobody else does.
    always_comb begin
        any   = |req;
        grant = (req[r_ptr] || !req[~r_ptr]) ? r_ptr : ~r_ptr;
    end

endmodule
`default_nettype wire

// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : coherence_bus_ctrl
//  Purpose : Memory-side responder for two cores' L1 icache/dcache pairs.
//            Runs one transaction at a time. Data requests take precedence
//            over instruction fetches. Every data read snoops the other
//            dcache. A dirty snoop hit is forwarded cache-to-cache and
//            written back to RAM in the same access. All other requests
//            are served from the single-ported RAM.
//  Ports   : CLK, nRST              - clock, asynchronous active-low reset
//            iREN/iaddr/iwait/iload - per-core instruction fetch port
//            dREN/dWEN/daddr/dstore/dwait/dload
//                                   - per-core data port
//            cctrans/ccwrite        - per-core coherence status in
//            ccwait/ccinv/ccsnoopaddr
//                                   - per-core snoop control out
//            ramREN/ramWEN/ramaddr/ramstore/ramload/ramwait
//                                   - RAM port
//  Rev     : 1.0  initial release
// ============================================================================
module coherence_bus_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CPUS   = 2,   // only 2 is supported
    parameter int WORD_W = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [CPUS-1:0]              iREN,
    input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
    output logic [CPUS-1:0]              iwait,
    output logic [CPUS-1:0][WORD_W-1:0]  iload,
    input  logic [CPUS-1:0]              dREN,
    input  logic [CPUS-1:0]              dWEN,
    input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
    input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
    output logic [CPUS-1:0]              dwait,
    output logic [CPUS-1:0][WORD_W-1:0]  dload,
    input  logic [CPUS-1:0]              cctrans,
    input  logic [CPUS-1:0]              ccwrite,
    output logic [CPUS-1:0]              ccwait,
    output logic [CPUS-1:0]              ccinv,
    output logic [CPUS-1:0][WORD_W-1:0]  ccsnoopaddr,
    output logic                         ramREN,
    output logic                         ramWEN,
    output logic [WORD_W-1:0]            ramaddr,
    output logic [WORD_W-1:0]            ramstore,
    input  logic [WORD_W-1:0]            ramload,
    input  logic                         ramwait
);

    bus_state_t         r_state;
    bus_state_t         w_next;
    logic               r_grant;
    logic [WORD_W-1:0]  r_addr;
    logic               r_ccwrite;

    logic               w_other;
    logic [CPUS-1:0]    w_dreq;
    logic               w_d_any;
    logic               w_d_gnt;
    logic               w_i_any;
    logic               w_i_gnt;
    logic               w_d_done;
    logic               w_i_done;
    logic               w_latch_grant;
    logic               w_grant_nxt;
    logic               w_latch_addr;

    assign w_other = other_core(r_grant);
    assign w_dreq  = dREN | dWEN;

    rr_arbiter2 u_d_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req     (w_dreq),
        .advance (w_d_done),
        .grant   (w_d_gnt),
        .any     (w_d_any)
    );

    rr_arbiter2 u_i_arb (
        .clk     (CLK),
        .rst_n   (nRST),
        .req     (iREN),
        .advance (w_i_done),
        .grant   (w_i_gnt),
        .any     (w_i_any)
    );

    // Grant, snoop address and write intent are captured in IDLE so that
    // the requester may move its address bus while the snoop is answered.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_grant   <= 1'b0;
            r_addr    <= '0;
            r_ccwrite <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch_grant) begin
                r_grant <= w_grant_nxt;
            end
            if (w_latch_addr) begin
                r_addr    <= daddr[w_d_gnt];
                r_ccwrite <= ccwrite[w_d_gnt];
            end
        end
    end

    // All outputs are decoded from the state, so an asynchronous reset
    // forces them to their idle values without waiting for a clock edge.
    always_comb begin
        w_next        = r_state;
        w_latch_grant = 1'b0;
        w_grant_nxt   = 1'b0;
        w_latch_addr  = 1'b0;
        w_d_done      = 1'b0;
        w_i_done      = 1'b0;
        iwait         = '1;
        dwait         = '1;
        iload         = '0;
        dload         = '0;
        ccwait        = '0;
        ccinv         = '0;
        ccsnoopaddr   = '0;
        ramREN        = 1'b0;
        ramWEN        = 1'b0;
        ramaddr       = '0;
        ramstore      = '0;

        unique case (r_state)
            IDLE: begin
                if (w_d_any) begin
                    w_latch_grant = 1'b1;
                    w_grant_nxt   = w_d_gnt;
                    // Writebacks carry no coherence side effects: no snoop.
                    if (dWEN[w_d_gnt]) begin
                        w_next = DWRITE;
                    end else begin
                        w_latch_addr = 1'b1;
                        w_next       = SNOOP;
                    end
                end else if (w_i_any) begin
                    w_latch_grant = 1'b1;
                    w_grant_nxt   = w_i_gnt;
                    w_next        = IFETCH;
                end
            end

            SNOOP: begin
                ccwait[w_other]      = 1'b1;
                ccsnoopaddr[w_other] = r_addr;
                ccinv[w_other]       = r_ccwrite;
                if (cctrans[w_other] && ccwrite[w_other] && dWEN[w_other]) begin
                    w_next = C2C;
                end else begin
                    w_next = RAM_RD;
                end
            end

            C2C: begin
                // The supplier's writeback doubles as the requester's fill.
                ccwait[w_other] = 1'b1;
                ramWEN          = 1'b1;
                ramaddr         = daddr[w_other];
                ramstore        = dstore[w_other];
                dload[r_grant]  = dstore[w_other];
                if (!ramwait) begin
                    dwait[r_grant] = 1'b0;
                    dwait[w_other] = 1'b0;
                    w_d_done       = 1'b1;
                    w_next         = IDLE;
                end
            end

            RAM_RD: begin
                if (!dREN[r_grant]) begin
                    w_next = IDLE;
                end else begin
                    ramREN         = 1'b1;
                    ramaddr        = r_addr;
                    dload[r_grant] = ramload;
                    if (!ramwait) begin
                        dwait[r_grant] = 1'b0;
                        w_d_done       = 1'b1;
                        w_next         = IDLE;
                    end
                end
            end

            DWRITE: begin
                if (!dWEN[r_grant]) begin
                    w_next = IDLE;
                end else begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[r_grant];
                    ramstore = dstore[r_grant];
                    if (!ramwait) begin
                        dwait[r_grant] = 1'b0;
                        w_d_done       = 1'b1;
                        w_next         = IDLE;
                    end
                end
            end

            IFETCH: begin
                if (!iREN[r_grant]) begin
                    w_next = IDLE;
                end else begin
                    ramREN         = 1'b1;
                    ramaddr        = iaddr[r_grant];
                    iload[r_grant] = ramload;
                    if (!ramwait) begin
                        iwait[r_grant] = 1'b0;
                        w_i_done       = 1'b1;
                        w_next         = IDLE;
                    end
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Memory-side responder for the cache coherence interface used by both cores' L1 caches.
- Arbitrates instruction-fetch and data requests from two cores and issues snoops to the non-requesting dcache.
- On a snoop hit it forwards dirty data cache-to-cache with writeback; otherwise it serves the request from RAM.
- Sits between the two cores' icache/dcache pairs and the single-ported RAM.

Parameters:
CPUS, 2, number of cores; only 2 is supported.
WORD_W, 32, data and address width.

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
iREN  in  CPUS  icache read request per core
iaddr  in  CPUS x WORD_W  icache read address
iwait  out  CPUS  low for one cycle when iload is valid
iload  out  CPUS x WORD_W  instruction word returned
dREN  in  CPUS  dcache read request
dWEN  in  CPUS  dcache write request (writeback, flush or snoop supply)
daddr  in  CPUS x WORD_W  dcache address
dstore  in  CPUS x WORD_W  dcache write data
dwait  out  CPUS  low for one cycle when a data transaction completes
dload  out  CPUS x WORD_W  data returned
cctrans  in  CPUS  cache is in a coherence transaction or is answering a snoop
ccwrite  in  CPUS  write intent, or dirty snoop hit when answering
ccwait  out  CPUS  snoop in progress; the cache must hold off
ccinv  out  CPUS  snooped line must be invalidated
ccsnoopaddr  out  CPUS x WORD_W  snoop address
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramwait  in  1  RAM not ready; access completes in a cycle with ramwait low

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; dwait and iwait all 1; ccwait, ccinv and ccsnoopaddr 0; ramREN, ramWEN, ramaddr and ramstore 0; dload and iload 0; both round-robin pointers favour core 0.
- One transaction at a time. dcache requests take priority over icache requests. Separate 1-bit round-robin pointers exist for the d and i sides; a pointer flips only when a grant is completed.
- State IDLE:
  - Grant g = arbiter winner among cores with dREN|dWEN.
  - If the granted core's dWEN is set: go to DWRITE (writebacks are not snooped).
  - If the granted core's dREN is set: latch g, daddr[g] and ccwrite[g]; go to SNOOP.
  - Else, if any iREN is set: latch the i-grant; go to IFETCH.
  - A request seen in IDLE is serviced starting the next cycle.
- State SNOOP (exactly 1 cycle):
  - o = other core. Drive ccwait[o]=1, ccsnoopaddr[o]=latched addr, ccinv[o]=latched ccwrite.
  - If cctrans[o]&ccwrite[o]&dWEN[o] (dirty hit supplying data): go to C2C; else go to RAM_RD.
- State C2C:
  - ccwait[o] held at 1.
  - ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o]; dload[g]=dstore[o].
  - In the cycle ramwait is low: dwait[g]=0 and dwait[o]=0 in the same cycle; go to IDLE.
- State RAM_RD:
  - ramREN=1, ramaddr=latched addr, dload[g]=ramload.
  - On !ramwait: dwait[g]=0; go to IDLE.
- State DWRITE:
  - ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g].
  - On !ramwait: dwait[g]=0; go to IDLE.
- State IFETCH:
  - ramREN=1, ramaddr=iaddr[g], iload[g]=ramload.
  - On !ramwait: iwait[g]=0; go to IDLE.
- Each word is a separate transaction. A two-word block fill is two consecutive transactions, each snooped.
- Minimum latency for a RAM read is 3 cycles (IDLE→SNOOP→RAM_RD) with ramwait low.
- Abort: if the granted core deasserts its request while in RAM_RD, DWRITE or IFETCH, drop the RAM strobes and return to IDLE next cycle with no ack and no pointer flip.
- A non-granted core's dwait and iwait stay 1 throughout.
- ccinv is only ever asserted together with ccwait.
- Reset mid-transaction: all outputs take their reset values immediately. The RAM access is abandoned; no partial state is retained.

Decomposition:
- cpu_types_pkg gains a bus_state_t enum (IDLE, SNOOP, C2C, RAM_RD, DWRITE, IFETCH) and a word_t-based per-core array typedef.
- One sub-module: rr_arbiter2 (2-requester round robin with request in, grant out and a done/advance input). It is instantiated twice, once for the d side and once for the i side.

Test Plan:
- Reset with random inputs → dwait=2'b11, iwait=2'b11, ccwait=0, ramREN=ramWEN=0. State stays IDLE until nRST rises.
- Core0 dREN at 0x100, core1 no hit, ramwait low after 2 cycles, ramload=0xDEADBEEF → one SNOOP cycle (ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=0), then ramREN at 0x100; dload[0]=0xDEADBEEF with dwait[0]=0 for exactly one cycle.
- Core1 dREN with ccwrite at 0x200; core0 answers cctrans/ccwrite/dWEN with dstore=0x12345678 → ccinv[0]=1 in SNOOP. C2C drives ramWEN at 0x200 with 0x12345678; dload[1]=0x12345678; dwait[0] and dwait[1] are both low in the same cycle.
- Both cores hold dREN for 4 transactions → grant order 0,1,0,1.
- dREN[0] and iREN[1] in the same cycle → data transaction first, then IFETCH at iaddr[1]; iload[1]=ramload with iwait[1]=0.
- nRST dropped during RAM_RD → ramREN falls asynchronously. After release the FSM is in IDLE and the d-side pointer favours core 0.
